traffic_light_fsm: RTL and testbench

Adaptive four-approach traffic-light controller for a single intersection. Per-approach vehicle sensors drive round-robin service:
- S1 is the near/presence sensor.
- S5 is the far/queue-long sensor.

Approaches with no demand are skipped. A congested approach gets an extended green. The block exposes its state and an encoded light command to the signal-head driver.

---
 rtl/traffic_pkg.sv | 71 +++++++
 rtl/next_approach_sel.sv | 37 +++
 rtl/traffic_light_fsm.sv | 151 +++++++++++++++
 tb/tb_traffic_light_fsm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the four-approach traffic-light controller:
//   - state_e     : FSM state codes (IDLE, then green/yellow per approach)
//   - approach_t  : 2-bit approach index (NS=0, SN=1, EW=2, WE=3)
//   - COL_*       : colour field of the light command
//   - helpers     : map between approach indices and green/yellow states and
//                   decode a state into the 4-bit light command
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef logic [1:0] approach_t;

    localparam approach_t APP_NS = 2'd0;
    localparam approach_t APP_SN = 2'd1;
    localparam approach_t APP_EW = 2'd2;
    localparam approach_t APP_WE = 2'd3;

    localparam logic [1:0] COL_RED    = 2'b00;
    localparam logic [1:0] COL_GREEN  = 2'b01;
    localparam logic [1:0] COL_YELLOW = 2'b10;

    // Green of approach a is 2a+1, its yellow is 2a+2.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_NS_G = 4'd1,
        ST_NS_Y = 4'd2,
        ST_SN_G = 4'd3,
        ST_SN_Y = 4'd4,
        ST_EW_G = 4'd5,
        ST_EW_Y = 4'd6,
        ST_WE_G = 4'd7,
        ST_WE_Y = 4'd8
    } state_e;

    function automatic state_e green_of(input approach_t app);
        return state_e'({1'b0, app, 1'b1});
    endfunction

    function automatic state_e yellow_of(input approach_t app);
        return state_e'({1'b0, app, 1'b0} + 4'd2);
    endfunction

    // Only meaningful for green/yellow states.
    function automatic approach_t approach_of(input state_e st);
        logic [3:0] off;
        off = st - 4'd1;
        return off[2:1];
    endfunction

    function automatic logic is_green(input state_e st);
        return st inside {ST_NS_G, ST_SN_G, ST_EW_G, ST_WE_G};
    endfunction

    function automatic logic is_yellow(input state_e st);
        return st inside {ST_NS_Y, ST_SN_Y, ST_EW_Y, ST_WE_Y};
    endfunction

    // {approach, colour}; IDLE and any illegal code show all-red 0000.
    function automatic logic [3:0] light_of(input state_e st);
        logic [3:0] l;
        l = {APP_NS, COL_RED};
        if (is_green(st)) begin
            l = {approach_of(st), COL_GREEN};
        end else if (is_yellow(st)) begin
            l = {approach_of(st), COL_YELLOW};
        end
        return l;
    endfunction

endpackage

// File: rtl/next_approach_sel.sv
// -----------------------------------------------------------------------------
// next_approach_sel
// Combinational round-robin picker. Scans the demand vector starting at
// `start` and wrapping (start, start+1, start+2, start+3) and returns the
// first approach with demand.
//   demand [3:0] : per-approach demand, bit index = approach index
//   start  [1:0] : first approach to examine
//   valid        : some approach demands
//   idx    [1:0] : selected approach (equals start when !valid)
// -----------------------------------------------------------------------------
module next_approach_sel
    import traffic_pkg::*;
(
    input  logic [3:0] demand,
    input  approach_t  start,
    output logic       valid,
    output approach_t  idx
);

    approach_t cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise synthesis infers a latch.
        valid = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = 0; i < 4; i++) begin
            cand = start + approach_t'(i);
            if (!valid && demand[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// -----------------------------------------------------------------------------
// traffic_light_fsm
// Adaptive round-robin controller for a four-approach intersection.
// Approaches without demand are skipped; an approach whose queue-long sensor
// is high when its base green expires gets an extended green. A green with no
// competing demand is held while its own demand persists.
//   clk              : rising-edge clock
//   rst              : asynchronous active-low reset (all-red, IDLE)
//   <d>_S1           : presence sensor of approach d (NS, SN, EW, WE)
//   <d>_S5           : queue-long sensor of approach d
//   state      [3:0] : current state code (state_e)
//   light_signal[3:0]: {approach, colour}, registered Moore decode of state
// Sensors must already be synchronous to clk.
// -----------------------------------------------------------------------------
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int T_GREEN     = 4,
    parameter int T_GREEN_MAX = 8,
    parameter int T_YELLOW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       NS_S1,
    input  logic       SN_S1,
    input  logic       EW_S1,
    input  logic       WE_S1,
    input  logic       NS_S5,
    input  logic       SN_S5,
    input  logic       EW_S5,
    input  logic       WE_S5,
    output logic [3:0] state,
    output logic [3:0] light_signal
);

    localparam int CNT_MAX = (T_GREEN_MAX > T_YELLOW) ? T_GREEN_MAX : T_YELLOW;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] GM_LAST = CNT_W'(T_GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(T_YELLOW - 1);
    // With equal lengths an extension would change nothing.
    localparam logic             EXT_EN  = (T_GREEN_MAX > T_GREEN);

    state_e           state_q, next_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    approach_t        ptr_q, ptr_d;
    logic             ext_q, ext_d;
    logic [3:0]       light_q, light_d;

    logic [3:0]       demand, queue_long;
    approach_t        cur_app;
    logic             own_demand, own_long, other_demand;
    logic [CNT_W-1:0] green_last;
    logic             sel_valid;
    approach_t        sel_idx;
    approach_t        sel_start;

    assign demand     = {WE_S1 | WE_S5, EW_S1 | EW_S5, SN_S1 | SN_S5, NS_S1 | NS_S5};
    assign queue_long = {WE_S5, EW_S5, SN_S5, NS_S5};

    assign cur_app      = approach_of(state_q);
    assign own_demand   = demand[cur_app];
    assign own_long     = queue_long[cur_app];
    assign other_demand = |(demand & ~(4'b0001 << cur_app));
    assign green_last   = ext_q ? GM_LAST : G_LAST;

    // The pointer always holds the approach most recently given green, so
    // the search from IDLE and from the yellow of approach d (= pointer)
    // both start one past it, and d itself is considered last.
    assign sel_start = ptr_q + 2'd1;

    next_approach_sel u_sel (
        .demand (demand),
        .start  (sel_start),
        .valid  (sel_valid),
        .idx    (sel_idx)
    );

    always_comb begin
        next_state = state_q;
        ext_d      = ext_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    next_state = green_of(sel_idx);
                end
            end

            ST_NS_G, ST_SN_G, ST_EW_G, ST_WE_G: begin
                if (EXT_EN && !ext_q && (cnt_q == G_LAST) && own_long) begin
                    // Extension is latched here; S5 dropping later cannot
                    // shorten the green.
                    ext_d = 1'b1;
                end else if (cnt_q >= green_last) begin
                    // Past the exit point the green is held only while the
                    // approach still demands and nobody else is waiting.
                    if (other_demand || !own_demand) begin
                        next_state = yellow_of(cur_app);
                    end
                end
            end

            ST_NS_Y, ST_SN_Y, ST_EW_Y, ST_WE_Y: begin
                if (cnt_q >= Y_LAST) begin
                    next_state = sel_valid ? green_of(sel_idx) : ST_IDLE;
                end
            end

            default: next_state = ST_IDLE;
        endcase

        if (next_state != state_q) begin
            cnt_d = '0;
            ext_d = 1'b0;
            if (is_green(next_state)) begin
                ptr_d = approach_of(next_state);
            end
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Decoding next_state keeps the registered light aligned with state_q.
        light_d = light_of(next_state);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= APP_WE;
            ext_q   <= 1'b0;
            light_q <= 4'b0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples values from before this edge.
            state_q <= next_state;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ext_q   <= ext_d;
            light_q <= light_d;
        end
    end

    assign state        = state_q;
    assign light_signal = light_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_fsm
// Scoreboard bench for traffic_light_fsm. Each driven cycle advances a
// behavioural model (phase / approach / elapsed-cycle bookkeeping) and pushes
// the expected state code; a monitor pops one entry after every rising edge
// and compares state and light_signal. Directed scenarios add fixed-value
// expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_traffic_light_fsm;

    localparam int T_GREEN     = 4;
    localparam int T_GREEN_MAX = 8;
    localparam int T_YELLOW    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       NS_S1 = 1'b0, SN_S1 = 1'b0, EW_S1 = 1'b0, WE_S1 = 1'b0;
    logic       NS_S5 = 1'b0, SN_S5 = 1'b0, EW_S5 = 1'b0, WE_S5 = 1'b0;
    logic [3:0] state;
    logic [3:0] light_signal;

    traffic_light_fsm #(
        .T_GREEN     (T_GREEN),
        .T_GREEN_MAX (T_GREEN_MAX),
        .T_YELLOW    (T_YELLOW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .NS_S1        (NS_S1),
        .SN_S1        (SN_S1),
        .EW_S1        (EW_S1),
        .WE_S1        (WE_S1),
        .NS_S5        (NS_S5),
        .SN_S5        (SN_S5),
        .EW_S5        (EW_S5),
        .WE_S5        (WE_S5),
        .state        (state),
        .light_signal (light_signal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    // Light command per state code, straight from the decode table.
    int light_tbl[9] = '{0, 1, 2, 5, 6, 9, 10, 13, 14};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_phase;   // 0 = all red, 1 = green, 2 = yellow
    int m_app;     // approach currently shown
    int m_cyc;     // cycles spent so far in the current phase
    int m_len;     // green length currently in force
    int m_last;    // approach most recently given green

    function automatic int pick(input logic [3:0] dem, input int from);
        for (int k = 0; k < 4; k++) begin
            int a;
            a = (from + k) % 4;
            if (dem[a]) return a;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_app   = 0;
        m_cyc   = 0;
        m_len   = T_GREEN;
        m_last  = 3;
    endtask

    task automatic enter_green(input int a);
        m_phase = 1;
        m_app   = a;
        m_cyc   = 1;
        m_len   = T_GREEN;
        m_last  = a;
    endtask

    task automatic model_step(input logic [3:0] s1, input logic [3:0] s5);
        logic [3:0] dem;
        int         a;
        dem = s1 | s5;
        case (m_phase)
            0: begin
                a = pick(dem, (m_last + 1) % 4);
                if (a >= 0) enter_green(a);
            end
            1: begin
                if (m_cyc == T_GREEN && s5[m_app] && m_len == T_GREEN && T_GREEN_MAX > T_GREEN) begin
                    m_len = T_GREEN_MAX;
                    m_cyc++;
                end else if (m_cyc >= m_len &&
                             ((dem & ~(4'(1 << m_app))) != 4'd0 || !dem[m_app])) begin
                    m_phase = 2;
                    m_cyc   = 1;
                end else begin
                    m_cyc++;
                end
            end
            default: begin
                if (m_cyc >= T_YELLOW) begin
                    a = pick(dem, (m_app + 1) % 4);
                    if (a >= 0) enter_green(a);
                    else begin
                        m_phase = 0;
                        m_cyc   = 0;
                    end
                end else begin
                    m_cyc++;
                end
            end
        endcase
    endtask

    function automatic int model_code();
        if (m_phase == 0) return 0;
        return 1 + 2 * m_app + ((m_phase == 2) ? 1 : 0);
    endfunction

    // ---------------- stimulus ----------------
    // Drives one cycle's sensors at the falling edge, optionally pulsing the
    // asynchronous reset inside the low phase, and queues the expected state
    // for the following rising edge.
    task automatic drive(input logic [3:0] s1, input logic [3:0] s5, input bit pulse);
        @(negedge clk);
        rst = 1'b1;
        {WE_S1, EW_S1, SN_S1, NS_S1} = s1;
        {WE_S5, EW_S5, SN_S5, NS_S5} = s5;
        if (pulse) begin
            #1 rst = 1'b0;
            #1;
            check("async_rst_state", 32'(state), 0);
            check("async_rst_light", 32'(light_signal), 0);
            model_reset();
            #1 rst = 1'b1;
        end
        model_step(s1, s5);
        exp_q.push_back(model_code());
    endtask

    task automatic step(input logic [3:0] s1, input logic [3:0] s5, input bit pulse,
                        input int exp_code, input string tag);
        drive(s1, s5, pulse);
        @(posedge clk);
        #1;
        check({tag, "_state"}, 32'(state), exp_code);
        check({tag, "_light"}, 32'(light_signal), light_tbl[exp_code]);
    endtask

    task automatic run_phase(input logic [3:0] s1, input logic [3:0] s5,
                             input int exp_code, input int n, input string tag);
        for (int i = 0; i < n; i++) step(s1, s5, 1'b0, exp_code, tag);
    endtask

    // ---------------- monitor ----------------
    initial begin
        int code;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                code = exp_q.pop_front();
                check("sb_state", 32'(state), code);
                check("sb_light", 32'(light_signal), light_tbl[code]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] rs1, rs5;
        bit         pulse;

        model_reset();
        #3;
        check("por_state", 32'(state), 0);
        check("por_light", 32'(light_signal), 0);
        @(posedge clk);
        #1;
        check("por_hold_state", 32'(state), 0);

        // No demand: stay all-red.
        run_phase(4'b0000, 4'b0000, 0, 3, "idle");
        // NS presence only: 1-cycle entry, indefinite hold, 2-cycle yellow.
        step(4'b0001, 4'b0000, 1'b0, 1, "ns_enter");
        run_phase(4'b0001, 4'b0000, 1, 12, "ns_hold");
        run_phase(4'b0000, 4'b0000, 2, 2, "ns_yel");
        run_phase(4'b0000, 4'b0000, 0, 3, "ns_idle");

        // NS and SN alternate with base greens.
        step(4'b0011, 4'b0000, 1'b1, 1, "alt");
        run_phase(4'b0011, 4'b0000, 1, 3, "alt_ns");
        run_phase(4'b0011, 4'b0000, 2, 2, "alt_nsy");
        run_phase(4'b0011, 4'b0000, 3, 4, "alt_sn");
        run_phase(4'b0011, 4'b0000, 4, 2, "alt_sny");
        run_phase(4'b0011, 4'b0000, 1, 4, "alt_ns2");
        run_phase(4'b0011, 4'b0000, 2, 2, "alt_nsy2");
        step(4'b0011, 4'b0000, 1'b0, 3, "alt_sn2");

        // NS queue-long with SN waiting: extended green of 8.
        step(4'b0010, 4'b0001, 1'b1, 1, "ext");
        run_phase(4'b0010, 4'b0001, 1, 7, "ext_ns");
        run_phase(4'b0010, 4'b0001, 2, 2, "ext_nsy");
        step(4'b0010, 4'b0001, 1'b0, 3, "ext_sn");

        // Demand moves to EW during NS green: SN skipped.
        step(4'b0001, 4'b0000, 1'b1, 1, "skip");
        run_phase(4'b0001, 4'b0000, 1, 1, "skip_ns");
        run_phase(4'b0100, 4'b0000, 1, 2, "skip_ns2");
        run_phase(4'b0100, 4'b0000, 2, 2, "skip_nsy");
        step(4'b0100, 4'b0000, 1'b0, 5, "skip_ew");

        // All sensors high, reset mid EW green, then full rotation.
        step(4'b1111, 4'b1111, 1'b1, 1, "all");
        run_phase(4'b1111, 4'b1111, 1, 7, "all_ns");
        run_phase(4'b1111, 4'b1111, 2, 2, "all_nsy");
        run_phase(4'b1111, 4'b1111, 3, 8, "all_sn");
        run_phase(4'b1111, 4'b1111, 4, 2, "all_sny");
        run_phase(4'b1111, 4'b1111, 5, 3, "all_ew");
        step(4'b1111, 4'b1111, 1'b1, 1, "all_rst");
        run_phase(4'b1111, 4'b1111, 1, 7, "rot_ns");
        run_phase(4'b1111, 4'b1111, 2, 2, "rot_nsy");
        run_phase(4'b1111, 4'b1111, 3, 8, "rot_sn");
        run_phase(4'b1111, 4'b1111, 4, 2, "rot_sny");
        run_phase(4'b1111, 4'b1111, 5, 8, "rot_ew");
        run_phase(4'b1111, 4'b1111, 6, 2, "rot_ewy");
        run_phase(4'b1111, 4'b1111, 7, 8, "rot_we");
        run_phase(4'b1111, 4'b1111, 8, 2, "rot_wey");
        step(4'b1111, 4'b1111, 1'b0, 1, "rot_wrap");

        // Randomized traffic; sensors change in bursts so holds and
        // extensions both occur, with occasional asynchronous resets.
        rs1 = 4'b0000;
        rs5 = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                rs1 = 4'($urandom & $urandom);
                rs5 = 4'($urandom & $urandom & $urandom);
            end
            pulse = ($urandom_range(0, 399) == 0);
            drive(rs1, rs5, pulse);
        end

        @(posedge clk);
        #2;
        check("sb_drain", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
